// File: rtl/sa_wresp_channel_pkg.sv
// Shared interconnect parameters for the write-response channel slice.
// Widths and default depths used by the dispatcher blocks.
package sa_wresp_channel_pkg;

  localparam int DEF_TRANS_MST_ID_W   = 5;
  localparam int DEF_TRANS_WR_RESP_W  = 2;
  localparam int DEF_OUTSTANDING_AMT  = 8;

endpackage

// File: rtl/sa_wresp_channel_fifo.sv
// Synchronous FIFO with occupancy counter; push is ignored when full,
// pop is ignored when empty. Read data is the current head (show-ahead).
module sa_wresp_channel_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Explicit wrap so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sa_wresp_channel.sv
// Write-response return path: routes slave B responses to the master that
// won the matching AW grant, using an in-order record of granted masters.
module sa_wresp_channel
  import sa_wresp_channel_pkg::*;
#(
  parameter int MST_AMT         = 2,
  parameter int OUTSTANDING_AMT = DEF_OUTSTANDING_AMT,
  parameter int OUTST_CTN_W     = $clog2(OUTSTANDING_AMT) + 1,
  parameter int TRANS_MST_ID_W  = DEF_TRANS_MST_ID_W,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_WR_RESP_W = DEF_TRANS_WR_RESP_W
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [TRANS_SLV_ID_W-1:0]           s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
  input  logic                                s_BVALID_i,
  output logic                                s_BREADY_o,
  input  logic [MST_ID_W-1:0]                 aw_mst_id_i,
  input  logic                                aw_shift_en_i,
  output logic [OUTST_CTN_W-1:0]              aw_B_outst_ctn_o,
  output logic                                aw_B_full_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  dsp_BRESP_o,
  output logic [MST_AMT-1:0]                  dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                  dsp_BREADY_i,
  output logic                                err_o
);

  // Handshakes: a transfer occurs on a rising edge with valid & ready both
  // high; valid is never lowered or altered until its transfer completes.

  logic [MST_ID_W-1:0]        order_head;
  logic                       order_empty;
  logic                       order_full;
  logic                       slv_accept;
  logic                       stage_pop;
  logic                       id_mismatch;

  logic                       stage_valid;
  logic [MST_ID_W-1:0]        stage_dest;
  logic [TRANS_MST_ID_W-1:0]  stage_bid;
  logic [TRANS_WR_RESP_W-1:0] stage_bresp;

  sa_wresp_channel_fifo #(
    .DATA_WIDTH (MST_ID_W),
    .FIFO_DEPTH (OUTSTANDING_AMT),
    .CNT_W      (OUTST_CTN_W)
  ) u_order_fifo (
    .clk     (ACLK_i),
    .rst_n   (ARESETn_i),
    .wr_en   (aw_shift_en_i),
    .wr_data (aw_mst_id_i),
    .rd_en   (slv_accept),
    .rd_data (order_head),
    .empty   (order_empty),
    .full    (order_full),
    .count   (aw_B_outst_ctn_o)
  );

  assign aw_B_full_o = order_full;
  assign stage_pop   = stage_valid & dsp_BREADY_i[stage_dest];
  // Never accept a response without a recorded owner for it.
  assign s_BREADY_o  = ~order_empty & (~stage_valid | stage_pop);
  assign slv_accept  = s_BVALID_i & s_BREADY_o;
  assign id_mismatch = (s_BID_i[TRANS_SLV_ID_W-1:TRANS_MST_ID_W] != order_head);

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      stage_valid <= 1'b0;
      stage_dest  <= '0;
      stage_bid   <= '0;
      stage_bresp <= '0;
    end else if (slv_accept) begin
      stage_valid <= 1'b1;
      stage_dest  <= order_head;
      stage_bid   <= s_BID_i[TRANS_MST_ID_W-1:0];
      stage_bresp <= s_BRESP_i;
    end else if (stage_pop) begin
      stage_valid <= 1'b0;
    end
  end

  // Sticky: dropped AW record or response ID disagreeing with grant order.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      err_o <= 1'b0;
    end else if ((aw_shift_en_i & order_full) | (slv_accept & id_mismatch)) begin
      err_o <= 1'b1;
    end
  end

  assign dsp_BID_o   = {MST_AMT{stage_bid}};
  assign dsp_BRESP_o = {MST_AMT{stage_bresp}};

  for (genvar k = 0; k < MST_AMT; k++) begin : g_dsp_valid
    assign dsp_BVALID_o[k] = stage_valid & (stage_dest == MST_ID_W'(k));
  end

endmodule

// File: doc/sa_wresp_channel.md
SA_WRESP_CHANNEL -- requirements
Module: sa_wresp_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 2, number of master dispatchers served.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8, order-FIFO depth.
REQ-003 SHALL have parameter OUTST_CTN_W, default $clog2(OUTSTANDING_AMT)+1, counter width.
REQ-004 SHALL have parameter TRANS_MST_ID_W, default 5, master transaction ID width.
REQ-005 SHALL have parameter MST_ID_W, default $clog2(MST_AMT), master index width.
REQ-006 SHALL have parameter TRANS_SLV_ID_W, default TRANS_MST_ID_W+MST_ID_W, slave-side BID width ({mst_idx, mst_BID}).
REQ-007 SHALL have parameter TRANS_WR_RESP_W, default 2, BRESP width.
REQ-008 Ports: ACLK_i  in  1  clock; one clock domain.
REQ-009 ARESETn_i  in  1  reset, asynchronous, active-low.
REQ-010 s_BID_i  in  TRANS_SLV_ID_W  slave response ID.
REQ-011 s_BRESP_i  in  TRANS_WR_RESP_W  slave response code.
REQ-012 s_BVALID_i  in  1 / s_BREADY_o  out  1  slave B handshake.
REQ-013 aw_mst_id_i  in  MST_ID_W  master granted on AW arbitration.
REQ-014 aw_shift_en_i  in  1  AW grant accepted by slave; push aw_mst_id_i.
REQ-015 aw_B_outst_ctn_o  out  OUTST_CTN_W  order-FIFO occupancy; aw_B_full_o  out  1  order FIFO full.
REQ-016 dsp_BID_o  out  TRANS_MST_ID_W*MST_AMT  per-master BID, slice k for master k.
REQ-017 dsp_BRESP_o  out  TRANS_WR_RESP_W*MST_AMT  per-master BRESP.
REQ-018 dsp_BVALID_o  out  MST_AMT / dsp_BREADY_i  in  MST_AMT  per-master B handshake.
REQ-019 err_o  out  1  sticky master-index mismatch flag.

Function
REQ-020 Order FIFO SHALL push aw_mst_id_i when aw_shift_en_i=1 and not full; push while full SHALL be dropped and set err_o.
REQ-021 Simultaneous push and pop SHALL leave aw_B_outst_ctn_o unchanged; head advances, new entry stored.
REQ-022 Output stage: one register {dest, BID, BRESP, valid}; stage_pop = valid & dsp_BREADY_i[dest].
REQ-023 s_BREADY_o SHALL equal ~order_empty & (~valid | stage_pop); no bypass of an empty order FIFO.
REQ-024 On s_BVALID_i & s_BREADY_o: stage loads dest=order head, BID=s_BID_i[TRANS_MST_ID_W-1:0], BRESP=s_BRESP_i, valid=1; order FIFO pops same edge.
REQ-025 Stage pop without load SHALL clear valid; pop with load SHALL replace contents (full throughput, one response per cycle).
REQ-026 dsp_BVALID_o[k] SHALL be valid & (dest==k); dsp_BID_o/dsp_BRESP_o slice k SHALL carry stage data for all k (only valid slice meaningful).
REQ-027 Latency slave handshake to dsp_BVALID_o SHALL be exactly 1 cycle.
REQ-028 Stage contents SHALL hold stable while valid & ~dsp_BREADY_i[dest].
REQ-029 If s_BID_i[TRANS_SLV_ID_W-1:TRANS_MST_ID_W] != order head at accept, routing SHALL still follow order head and err_o SHALL set.
REQ-030 aw_B_full_o SHALL equal (aw_B_outst_ctn_o==OUTSTANDING_AMT); AW arbitration stalls on it.

Reset
REQ-031 ARESETn_i low SHALL immediately clear order FIFO, valid, err_o; outputs: s_BREADY_o=0, dsp_BVALID_o=0, aw_B_outst_ctn_o=0, aw_B_full_o=0, dsp_BID_o=0, dsp_BRESP_o=0.
REQ-032 Reset mid-transfer SHALL discard held responses; no handshake completes in the reset-release cycle beyond normal rules.

Structure
REQ-033 Widths/defaults (TRANS_MST_ID_W, TRANS_WR_RESP_W, OUTSTANDING_AMT) SHALL come from the shared interconnect parameter package.
REQ-034 Order FIFO SHALL instantiate the existing fifo sub-module (DATA_WIDTH=MST_ID_W, FIFO_DEPTH=OUTSTANDING_AMT, counter to aw_B_outst_ctn_o).

Verification (MST_AMT=2, OUTSTANDING_AMT=4)
REQ-035 Push mst 1, then s_BID=6'b1_00011, BRESP=0 -> next cycle dsp_BVALID_o=2'b10, slice1 BID=5'd3.
REQ-036 Response offered with empty order FIFO -> s_BREADY_o=0 until push; then accepted, routed.
REQ-037 Push 0,1,0,1; responses back-to-back, all dsp_BREADY_i=1 -> four valids in 4 consecutive cycles in order 0,1,0,1; counter 4->0.
REQ-038 dsp_BREADY_i[0]=0 holding stage -> s_BREADY_o=0, stage stable; release -> drains, counter decrements.
REQ-039 Head=0, s_BID upper bit=1 -> routed to master 0, err_o=1 until reset.
REQ-040 Fill to 4 then push again -> aw_B_full_o=1, push dropped, err_o=1; async reset mid-burst -> all outputs 0 immediately.
